// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_pkg
// Brief    : Digit widths, BCD limits, the packed MM:SS time type and the
//            modulo-60 BCD helpers shared by the stopwatch slice.
// Revision : 1.0  initial release
// ============================================================================
package stopwatch_pkg;

    localparam int MT_W = 3;
    localparam int MU_W = 4;
    localparam int ST_W = 3;
    localparam int SU_W = 4;

    localparam logic [MT_W-1:0] TENS_MAX  = 3'd5;
    localparam logic [MU_W-1:0] UNITS_MAX = 4'd9;

    typedef struct packed {
        logic [MT_W-1:0] m10;
        logic [MU_W-1:0] m1;
        logic [ST_W-1:0] s10;
        logic [SU_W-1:0] s1;
    } sw_time_t;

    // True when a {tens,units} pair sits at 59 and the next step wraps.
    function automatic logic bcd60_last(input logic [2:0] tens, input logic [3:0] units);
        return (tens == TENS_MAX) && (units == UNITS_MAX);
    endfunction

    function automatic logic [6:0] bcd60_inc(input logic [2:0] tens, input logic [3:0] units);
        if (units == UNITS_MAX) begin
            if (tens == TENS_MAX) begin
                return 7'd0;
            end
            return {tens + 3'd1, 4'd0};
        end
        return {tens, units + 4'd1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_counter_if
// Brief    : Control inputs and BCD digit outputs of the stopwatch core.
// Revision : 1.0  initial release
// ============================================================================
interface stopwatch_counter_if;
    import stopwatch_pkg::*;

    logic            pause;
    logic            sel;
    logic            adj;
    logic            rstB;
    logic            pauseB;
    logic [MT_W-1:0] m10;
    logic [MU_W-1:0] m1;
    logic [ST_W-1:0] s10;
    logic [SU_W-1:0] s1;

    modport master (output pause, sel, adj, rstB, pauseB, input m10, m1, s10, s1);
    modport slave  (input pause, sel, adj, rstB, pauseB, output m10, m1, s10, s1);

endinterface
`default_nettype wire

// File: rtl/stopwatch_counter_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Brief    : 2-FF synchronizer, optional debouncer (DEBOUNCE_EN) and rising
//            edge detector producing a one-cycle pulse per accepted press.
// Revision : 1.0  initial release
// ============================================================================
module button_conditioner
`ifdef DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYC = 1_000_000
)
`endif
(
    input  wire clkAdj,
    input  wire rst,
    input  wire btn_raw,
    output wire btn_pulse
);

    logic [1:0] r_sync;
    logic       r_prev;
    logic       w_level;

    always_ff @(posedge clkAdj or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], btn_raw};
        end
    end

`ifdef DEBOUNCE_EN
    localparam int c_DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [c_DB_W-1:0] c_DB_ONE  = c_DB_W'(1);

    logic              r_stable;
    logic [c_DB_W-1:0] r_db_cnt;

    // A new level is only accepted after it has been seen on every edge of the window.
    always_ff @(posedge clkAdj or posedge rst) begin
        if (rst) begin
            r_stable <= 1'b0;
            r_db_cnt <= '0;
        end else if (r_sync[1] == r_stable) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == c_DB_LAST) begin
            r_stable <= r_sync[1];
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + c_DB_ONE;
        end
    end

    assign w_level = r_stable;
`else
    assign w_level = r_sync[1];
`endif

    always_ff @(posedge clkAdj or posedge rst) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign btn_pulse = w_level & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/stopwatch_counter.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_counter
// Brief    : MM:SS stopwatch core with 1 Hz count, 2 Hz adjust, pause toggle
//            and button clear; DEBOUNCE_EN enables button debouncing.
// Revision : 1.0  initial release
// ============================================================================
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int ONE_HZ_DIV   = 100_000_000,
    parameter int ADJ_DIV      = 50_000_000
`ifdef DEBOUNCE_EN
   ,parameter int DEBOUNCE_CYC = 1_000_000
`endif
) (
    input  wire                 clkAdj,
    input  wire                 rst,
    stopwatch_counter_if.slave  bus
);

    localparam int c_DIV1_W = (ONE_HZ_DIV > 1) ? $clog2(ONE_HZ_DIV) : 1;
    localparam int c_DIV2_W = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;
    localparam logic [c_DIV1_W-1:0] c_DIV1_LAST = c_DIV1_W'(ONE_HZ_DIV - 1);
    localparam logic [c_DIV2_W-1:0] c_DIV2_LAST = c_DIV2_W'(ADJ_DIV - 1);
    localparam logic [c_DIV1_W-1:0] c_DIV1_ONE  = c_DIV1_W'(1);
    localparam logic [c_DIV2_W-1:0] c_DIV2_ONE  = c_DIV2_W'(1);

    localparam logic [0:0] c_ST_RUN   = 1'b0;
    localparam logic [0:0] c_ST_PAUSE = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic                w_running;
    logic                r_pause_d;
    logic                w_pause_pulse;
    logic                w_rstb_pulse;
    logic                w_pauseb_pulse;
    logic                w_toggle;
    logic [c_DIV1_W-1:0] r_div1;
    logic [c_DIV2_W-1:0] r_div2;
    logic                w_tick1;
    logic                w_tick_a;
    sw_time_t            r_time;
    sw_time_t            w_time_next;

`ifdef DEBOUNCE_EN
    button_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_rstb_cond (
        .clkAdj(clkAdj), .rst(rst), .btn_raw(bus.rstB), .btn_pulse(w_rstb_pulse));
    button_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_pauseb_cond (
        .clkAdj(clkAdj), .rst(rst), .btn_raw(bus.pauseB), .btn_pulse(w_pauseb_pulse));
`else
    button_conditioner u_rstb_cond (
        .clkAdj(clkAdj), .rst(rst), .btn_raw(bus.rstB), .btn_pulse(w_rstb_pulse));
    button_conditioner u_pauseb_cond (
        .clkAdj(clkAdj), .rst(rst), .btn_raw(bus.pauseB), .btn_pulse(w_pauseb_pulse));
`endif

    assign w_pause_pulse = bus.pause & ~r_pause_d;
    assign w_toggle      = w_pause_pulse | w_pauseb_pulse;

    always_ff @(posedge clkAdj or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_toggle) begin
            w_state_next = (r_state == c_ST_RUN) ? c_ST_PAUSE : c_ST_RUN;
        end
    end

    always_comb begin
        w_running = (r_state == c_ST_RUN);
    end

    assign w_tick1  = w_running && !bus.adj && (r_div1 == c_DIV1_LAST);
    assign w_tick_a = bus.adj && (r_div2 == c_DIV2_LAST);

    always_ff @(posedge clkAdj or posedge rst) begin
        if (rst) begin
            r_pause_d <= 1'b0;
            r_div1    <= '0;
            r_div2    <= '0;
            r_time    <= '0;
        end else begin
            r_pause_d <= bus.pause;
            r_time    <= w_time_next;

            if (w_rstb_pulse) begin
                r_div1 <= '0;
            end else if (w_running && !bus.adj) begin
                r_div1 <= w_tick1 ? '0 : r_div1 + c_DIV1_ONE;
            end

            // Adjust divider restarts from zero each time adjust mode is entered.
            if (w_rstb_pulse || !bus.adj) begin
                r_div2 <= '0;
            end else begin
                r_div2 <= w_tick_a ? '0 : r_div2 + c_DIV2_ONE;
            end
        end
    end

    always_comb begin
        w_time_next = r_time;
        if (w_rstb_pulse) begin
            w_time_next = '0;
        end else if (bus.adj) begin
            if (w_tick_a) begin
                if (bus.sel) begin
                    {w_time_next.s10, w_time_next.s1} = bcd60_inc(r_time.s10, r_time.s1);
                end else begin
                    {w_time_next.m10, w_time_next.m1} = bcd60_inc(r_time.m10, r_time.m1);
                end
            end
        end else if (w_tick1) begin
            {w_time_next.s10, w_time_next.s1} = bcd60_inc(r_time.s10, r_time.s1);
            if (bcd60_last(r_time.s10, r_time.s1)) begin
                {w_time_next.m10, w_time_next.m1} = bcd60_inc(r_time.m10, r_time.m1);
            end
        end
    end

    assign bus.m10 = r_time.m10;
    assign bus.m1  = r_time.m1;
    assign bus.s10 = r_time.s10;
    assign bus.s1  = r_time.s1;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_counter
// Brief    : Directed bench for stopwatch_counter (ONE_HZ_DIV=4, ADJ_DIV=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_stopwatch_counter;

    logic clkAdj;
    logic rst;
    int   vectors;
    int   miscompares;

    stopwatch_counter_if sw_if ();

    stopwatch_counter #(
        .ONE_HZ_DIV(4),
        .ADJ_DIV(2)
`ifdef DEBOUNCE_EN
       ,.DEBOUNCE_CYC(8)
`endif
    ) dut (
        .clkAdj(clkAdj),
        .rst(rst),
        .bus(sw_if.slave)
    );

    initial begin
        clkAdj = 1'b0;
        forever #5 clkAdj = ~clkAdj;
    end

    function automatic logic [13:0] mk(input int mm, input int ss);
        return {3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clkAdj);
        #1;
    endtask

    task automatic check(input string tag, input int mm, input int ss);
        logic [13:0] obs;
        logic [13:0] exp;
        obs = {sw_if.m10, sw_if.m1, sw_if.s10, sw_if.s1};
        exp = mk(mm, ss);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d%0d:%0d%0d expected %0d%0d:%0d%0d", tag,
                   obs[13:11], obs[10:7], obs[6:4], obs[3:0],
                   exp[13:11], exp[10:7], exp[6:4], exp[3:0]);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst          = 1'b1;
        sw_if.pause  = 1'b0;
        sw_if.sel    = 1'b0;
        sw_if.adj    = 1'b0;
        sw_if.rstB   = 1'b0;
        sw_if.pauseB = 1'b0;

        step(2);
        check("reset_state", 0, 0);
        rst = 1'b0;

        // Count: first increment on the fourth edge, seconds carry at :59.
        step(3);   check("pre_first_tick", 0, 0);
        step(1);   check("first_tick", 0, 1);
        step(232); check("count_00_59", 0, 59);
        step(4);   check("count_01_00", 1, 0);

        // Pause toggle.
        rst = 1'b1; step(1); rst = 1'b0;
        step(40);
        sw_if.pause = 1'b1; step(1); sw_if.pause = 1'b0;
        step(100); check("paused_hold", 0, 10);
        sw_if.pause = 1'b1; step(1); sw_if.pause = 1'b0;
        step(8);   check("resumed", 0, 12);

        // Full wrap.
        rst = 1'b1; step(1); rst = 1'b0;
        step(14396); check("wrap_59_59", 59, 59);
        step(4);     check("wrap_00_00", 0, 0);

        // Adjust minutes then seconds, no carry between fields.
        step(8);   check("pre_adjust", 0, 2);
        sw_if.adj = 1'b1; sw_if.sel = 1'b0;
        step(118); check("adj_min_59", 59, 2);
        step(2);   check("adj_min_wrap", 0, 2);
        sw_if.sel = 1'b1;
        step(112); check("adj_sec_58", 0, 58);
        step(4);   check("adj_sec_wrap", 0, 0);
        sw_if.adj = 1'b0; sw_if.sel = 1'b0;
        step(4);   check("post_adjust", 0, 1);

`ifdef DEBOUNCE_EN
        // Short glitch on pauseB must not toggle.
        sw_if.pauseB = 1'b1; step(5); sw_if.pauseB = 1'b0;
        step(15);  check("glitch_no_toggle", 0, 6);
`else
        // rstB clears time and dividers, keeps running.
        step(20);  check("pre_rstb", 0, 6);
        sw_if.rstB = 1'b1; step(5); sw_if.rstB = 1'b0;
        check("rstb_clear", 0, 0);
        step(2);   check("rstb_still_running", 0, 1);

        // pauseB held 10 cycles toggles once.
        sw_if.pauseB = 1'b1; step(10); sw_if.pauseB = 1'b0;
        check("pauseb_toggle", 0, 1);
        step(20);  check("pauseb_single", 0, 1);
        sw_if.pause = 1'b1; step(1); sw_if.pause = 1'b0;
        step(1);   check("pause_resume", 0, 2);

        // pause and pauseB edges in the same cycle give one flip.
        sw_if.pauseB = 1'b1; step(2);
        sw_if.pause = 1'b1; step(1); sw_if.pause = 1'b0;
        step(10); sw_if.pauseB = 1'b0;
        check("dual_edge_one_flip", 0, 2);
        sw_if.pause = 1'b1; step(1); sw_if.pause = 1'b0;
        step(1);   check("dual_resume", 0, 3);
`endif

        // Asynchronous reset between edges.
        #3 rst = 1'b1;
        #1 check("async_rst", 0, 0);
        step(1); rst = 1'b0;
        step(4);   check("after_async_rst", 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
